// File: rtl/pad_pkg.sv
// Shared types and field offsets for the 3-button pad scan sequencer.
package pad_pkg;

    localparam int unsigned PAD_PINS = 6;
    localparam int unsigned PAD_BTNS = 8;

    // Bit offsets of each pin within a pad's 6-bit field of pad_in
    localparam int unsigned PIN_0 = 0;
    localparam int unsigned PIN_1 = 1;
    localparam int unsigned PIN_2 = 2;
    localparam int unsigned PIN_3 = 3;
    localparam int unsigned PIN_5 = 4;
    localparam int unsigned PIN_8 = 5;

    // Bit indices of each button within a pad's 8-bit field of buttons
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_START = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HI,
        ST_SAMPLE_HI,
        ST_WAIT_LO,
        ST_SAMPLE_LO,
        ST_PUBLISH
    } pad_state_e;

    typedef struct packed {
        logic start;
        logic c;
        logic b;
        logic a;
        logic right;
        logic left;
        logic down;
        logic up;
    } pad_btn_t;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for asynchronous active-low pad pins; resets to released (all ones).
module pad_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_scan_sequencer.sv
// Frame-triggered scanner for NUM_PADS 3-button pads: two select phases per pad, publishes all at once.
// Optional PAD_EDGE_DETECT_EN enables the pressed rising-edge mask; otherwise pressed is tied to 0.
module pad_scan_sequencer
    import pad_pkg::*;
#(
    parameter int unsigned NUM_PADS      = 2,
    parameter int unsigned SETTLE_CYCLES = 50
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         frame_tick,
    input  logic                         en,
    input  logic [PAD_PINS*NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0]          pad_sel,
    output logic [PAD_BTNS*NUM_PADS-1:0] buttons,
    output logic [PAD_BTNS*NUM_PADS-1:0] pressed,
    output logic                         busy,
    output logic                         scan_done,
    output logic                         overrun
);

    localparam int unsigned PINS_W = PAD_PINS * NUM_PADS;
    localparam int unsigned PW     = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int unsigned CW     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(NUM_PADS - 1);

    pad_state_e                  state;
    logic [PW-1:0]               p;
    logic [CW-1:0]               cnt;
    pad_btn_t [NUM_PADS-1:0]     shadow;
    pad_btn_t [NUM_PADS-1:0]     shadow_nxt;
    logic [PINS_W-1:0]           sync_pins;
    logic [PAD_PINS-1:0]         cur_pins;

    pad_sync #(
        .WIDTH (PINS_W)
    ) u_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (pad_in),
        .q     (sync_pins)
    );

    // Synchronized pins of the pad currently being scanned
    always_comb begin
        cur_pins = '1;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (p == PW'(i)) begin
                cur_pins = sync_pins[i*PAD_PINS +: PAD_PINS];
            end
        end
    end

    // Shadow capture: select-high phase gives directions/B/C, select-low phase gives A/Start
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (p == PW'(i)) begin
                if (state == ST_SAMPLE_HI) begin
                    shadow_nxt[i].up    = ~cur_pins[PIN_0];
                    shadow_nxt[i].down  = ~cur_pins[PIN_1];
                    shadow_nxt[i].left  = ~cur_pins[PIN_2];
                    shadow_nxt[i].right = ~cur_pins[PIN_3];
                    shadow_nxt[i].b     = ~cur_pins[PIN_5];
                    shadow_nxt[i].c     = ~cur_pins[PIN_8];
                end else if (state == ST_SAMPLE_LO) begin
                    shadow_nxt[i].a     = ~cur_pins[PIN_5];
                    shadow_nxt[i].start = ~cur_pins[PIN_8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            p         <= '0;
            cnt       <= '0;
            pad_sel   <= '1;
            buttons   <= '0;
            shadow    <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
`ifdef PAD_EDGE_DETECT_EN
            pressed   <= '0;
`endif
        end else begin
            scan_done <= 1'b0;
            overrun   <= frame_tick && (state != ST_IDLE);
            shadow    <= shadow_nxt;

            case (state)
                ST_IDLE: begin
                    if (frame_tick && en) begin
                        state <= ST_WAIT_HI;
                        p     <= '0;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE_HI;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_SAMPLE_HI: begin
                    state   <= ST_WAIT_LO;
                    cnt     <= CNT_LOAD;
                    pad_sel <= ~(NUM_PADS'(1) << p);
                end
                ST_WAIT_LO: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_SAMPLE_LO: begin
                    pad_sel <= '1;
                    if (p == P_LAST) begin
                        state <= ST_PUBLISH;
                    end else begin
                        state <= ST_WAIT_HI;
                        p     <= p + PW'(1);
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_PUBLISH: begin
                    buttons   <= shadow;
`ifdef PAD_EDGE_DETECT_EN
                    pressed   <= shadow & ~buttons;
`endif
                    scan_done <= 1'b1;
                    busy      <= 1'b0;
                    p         <= '0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    pad_sel <= '1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef PAD_EDGE_DETECT_EN
    assign pressed = '0;
`endif

endmodule

// File: tb/tb_pad_scan_sequencer.sv
// Bench for pad_scan_sequencer: emulated 3-button pads driven from pad_sel, random button states vs. a pad-level model.
module tb_pad_scan_sequencer;

    localparam int unsigned NP      = 2;
    localparam int unsigned ST      = 4;
    localparam int          EXP_LAT = NP * (2 * ST + 2) + 1;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              en = 1'b1;
    logic [6*NP-1:0]   pad_in;
    logic [NP-1:0]     pad_sel;
    logic [8*NP-1:0]   buttons;
    logic [8*NP-1:0]   pressed;
    logic              busy;
    logic              scan_done;
    logic              overrun;

    // Emulated pad state: per pad {Start, C, B, A, Right, Left, Down, Up}, active-high
    logic [8*NP-1:0]   pad_btn = '0;
    logic              use_raw = 1'b0;
    logic [6*NP-1:0]   raw_pins = '1;

    logic [8*NP-1:0]   exp_buttons = '0;
    logic [8*NP-1:0]   exp_pressed = '0;

    int checks = 0;
    int failures = 0;

    pad_scan_sequencer #(
        .NUM_PADS      (NP),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .frame_tick (frame_tick),
        .en         (en),
        .pad_in     (pad_in),
        .pad_sel    (pad_sel),
        .buttons    (buttons),
        .pressed    (pressed),
        .busy       (busy),
        .scan_done  (scan_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // 3-button pad: select high shows Up/Down/Left/Right/B/C, select low shows A on pin5 and Start on pin8
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            pad_in[6*i+0] = ~pad_btn[8*i+0];
            pad_in[6*i+1] = ~pad_btn[8*i+1];
            pad_in[6*i+2] = pad_sel[i] ? ~pad_btn[8*i+2] : 1'b0;
            pad_in[6*i+3] = pad_sel[i] ? ~pad_btn[8*i+3] : 1'b0;
            pad_in[6*i+4] = pad_sel[i] ? ~pad_btn[8*i+5] : ~pad_btn[8*i+4];
            pad_in[6*i+5] = pad_sel[i] ? ~pad_btn[8*i+6] : ~pad_btn[8*i+7];
        end
        if (use_raw) pad_in = raw_pins;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: tick sampled at edge 0, then 40 edges observed; optional extra tick / en drop at edge n
    task automatic do_scan(input bit tick_en, input int extra_tick_at, input int en_drop_at,
                           output int lat, output int done_cnt, output int ovr_cnt,
                           output int busy_cnt, output bit early_change);
        logic [8*NP-1:0] b0;
        b0 = buttons;
        lat = 0; done_cnt = 0; ovr_cnt = 0; busy_cnt = 0; early_change = 1'b0;
        @(negedge clk);
        en = tick_en;
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        if (busy) busy_cnt++;
        for (int n = 1; n <= 40; n++) begin
            if (n == extra_tick_at) frame_tick = 1'b1;
            if (n == en_drop_at) en = 1'b0;
            @(posedge clk);
            #1 frame_tick = 1'b0;
            if (overrun) ovr_cnt++;
            if (busy) busy_cnt++;
            if (scan_done) begin
                done_cnt++;
                if (lat == 0) lat = n;
            end
            if (lat == 0 && buttons !== b0) early_change = 1'b1;
        end
        en = 1'b1;
    endtask

    task automatic model_publish(input logic [8*NP-1:0] seen);
`ifdef PAD_EDGE_DETECT_EN
        exp_pressed = seen & ~exp_buttons;
`else
        exp_pressed = '0;
`endif
        exp_buttons = seen;
    endtask

    task automatic scan_and_check(input string tag);
        int lat, dc, oc, bc;
        bit early;
        do_scan(1'b1, 0, 0, lat, dc, oc, bc, early);
        model_publish(use_raw ? '0 : pad_btn);
        chk({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        chk({tag, "_buttons"}, 32'(buttons), 32'(exp_buttons));
        chk({tag, "_pressed"}, 32'(pressed), 32'(exp_pressed));
        chk({tag, "_early"}, 32'(early), 32'd0);
        chk({tag, "_sel_idle"}, 32'(pad_sel), 32'h3);
        chk({tag, "_ovr"}, 32'(oc), 32'd0);
    endtask

    initial begin
        int lat, dc, oc, bc;
        bit early;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 32'(pad_sel), 32'h3);
        chk("rst_buttons", 32'(buttons), 32'h0);
        chk("rst_pressed", 32'(pressed), 32'h0);
        chk("rst_flags", {29'd0, busy, scan_done, overrun}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (3) @(posedge clk);

        // All pins released
        use_raw = 1'b1;
        raw_pins = '1;
        scan_and_check("allones");
        use_raw = 1'b0;

        // Pad0 B (pin5 low only while selected high), pad1 Start (pin8 low only while selected low)
        pad_btn = 16'h8020;
        scan_and_check("b_start");
        chk("b_start_value", 32'(buttons), 32'h8020);

        // Up released, pressed, then held
        pad_btn = 16'h0000;
        scan_and_check("up_rel");
        pad_btn = 16'h0001;
        scan_and_check("up_press");
        pad_btn = 16'h0001;
        scan_and_check("up_held");

        // Random pad states
        for (int k = 0; k < 6; k++) begin
            pad_btn = 16'($urandom);
            scan_and_check($sformatf("rand%0d", k));
        end

        // Tick while busy: single overrun, original scan unaffected
        pad_btn = 16'($urandom);
        do_scan(1'b1, 5, 0, lat, dc, oc, bc, early);
        model_publish(pad_btn);
        chk("ovr_lat", 32'(lat), 32'(EXP_LAT));
        chk("ovr_pulses", 32'(oc), 32'd1);
        chk("ovr_done_cnt", 32'(dc), 32'd1);
        chk("ovr_busy_cycles", 32'(bc), 32'(EXP_LAT));
        chk("ovr_buttons", 32'(buttons), 32'(exp_buttons));

        // en low at tick: nothing happens
        pad_btn = 16'($urandom);
        do_scan(1'b0, 0, 0, lat, dc, oc, bc, early);
        chk("en0_done", 32'(dc), 32'd0);
        chk("en0_busy", 32'(bc), 32'd0);
        chk("en0_buttons", 32'(buttons), 32'(exp_buttons));

        // en dropped mid-scan: scan still completes
        do_scan(1'b1, 0, 3, lat, dc, oc, bc, early);
        model_publish(pad_btn);
        chk("endrop_lat", 32'(lat), 32'(EXP_LAT));
        chk("endrop_buttons", 32'(buttons), 32'(exp_buttons));
        chk("endrop_pressed", 32'(pressed), 32'(exp_pressed));

        // Reset mid-scan at cycle 12 and at cycle 7 (pad0 selected low)
        for (int r = 0; r < 2; r++) begin
            int stop_at;
            stop_at = (r == 0) ? 12 : 7;
            pad_btn = 16'hFFFF;
            @(negedge clk);
            frame_tick = 1'b1;
            @(posedge clk);
            #1 frame_tick = 1'b0;
            repeat (stop_at) @(posedge clk);
            #1;
            if (r == 1) chk("rst_mid_sel_before", 32'(pad_sel), 32'h2);
            #2 clr_n = 1'b0;
            #1;
            chk($sformatf("rst_mid%0d_sel", r), 32'(pad_sel), 32'h3);
            chk($sformatf("rst_mid%0d_busy", r), 32'(busy), 32'd0);
            chk($sformatf("rst_mid%0d_buttons", r), 32'(buttons), 32'h0);
            exp_buttons = '0;
            exp_pressed = '0;
            @(negedge clk);
            clr_n = 1'b1;
            dc = 0;
            for (int n = 0; n < 30; n++) begin
                @(posedge clk);
                #1;
                if (scan_done) dc++;
            end
            chk($sformatf("rst_mid%0d_no_done", r), 32'(dc), 32'd0);
            chk($sformatf("rst_mid%0d_buttons_after", r), 32'(buttons), 32'h0);
        end

        // Normal operation after reset
        pad_btn = 16'($urandom);
        scan_and_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pad_scan_sequencer.md
PAD_SCAN_SEQUENCER -- requirements
Module: pad_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2: number of 3-button pads scanned per frame (1..4).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 50: clk cycles held after each select edge before sampling (min 3).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port clr_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle start-of-frame pulse.
REQ-006 SHALL have port en, input, 1: permits a frame_tick to start a scan.
REQ-007 SHALL have port pad_in, input, 6*NUM_PADS: per pad i, bits [6i+5:6i] = {pin8, pin5, pin3, pin2, pin1, pin0}, asynchronous, active-low.
REQ-008 SHALL have port pad_sel, output, NUM_PADS: pin6 drive per pad.
REQ-009 SHALL have port buttons, output, 8*NUM_PADS: per pad {Start, C, B, A, Right, Left, Down, Up}, active-high.
REQ-010 SHALL have port pressed, output, 8*NUM_PADS: rising-edge mask (see REQ-024).
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have port scan_done, output, 1: one-cycle pulse on publish.
REQ-013 SHALL have port overrun, output, 1: one-cycle pulse when frame_tick arrives while busy.

Function
REQ-014 SHALL pass pad_in through a 2-flop synchronizer before any use.
REQ-015 SHALL implement states IDLE, WAIT_HI, SAMPLE_HI, WAIT_LO, SAMPLE_LO, PUBLISH with a pad index p.
REQ-016 IDLE: frame_tick=1 and en=1 -> WAIT_HI, p=0; otherwise remain.
REQ-017 WAIT_HI: SETTLE_CYCLES cycles with pad_sel[p]=1, then SAMPLE_HI.
REQ-018 SAMPLE_HI: 1 cycle; captures Up, Down, Left, Right, B (pin5) and C (pin8) of pad p, inverted, into a shadow register; next state WAIT_LO.
REQ-019 WAIT_LO: SETTLE_CYCLES cycles with pad_sel[p]=0, then SAMPLE_LO.
REQ-020 SAMPLE_LO: 1 cycle; captures A (pin5) and Start (pin8) of pad p, inverted, with pad_sel[p]=0; next state is WAIT_HI with p+1, or PUBLISH if p=NUM_PADS-1.
REQ-021 Every pad_sel bit other than the active one SHALL be held at 1; all bits SHALL be 1 in IDLE and PUBLISH.
REQ-022 PUBLISH: 1 cycle; copies the shadow register into buttons for all pads at once, pulses scan_done, then returns to IDLE.
REQ-023 Timing: with frame_tick sampled at edge 0, scan_done SHALL be high for the cycle after edge NUM_PADS*(2*SETTLE_CYCLES+2)+1; buttons SHALL change only at that edge.
REQ-024 On each publish, pressed SHALL be set to new_buttons & ~old_buttons and held until the next publish.
REQ-025 A frame_tick while busy SHALL be ignored (no restart, no queue) and SHALL pulse overrun.
REQ-026 Deasserting en mid-scan SHALL NOT abort the scan; en gates only the start of a scan.
REQ-027 The settle counter SHALL be $clog2(SETTLE_CYCLES+1) bits wide and SHALL be reloaded on every WAIT entry.

Reset
REQ-028 While clr_n=0: state=IDLE, p=0, pad_sel all 1, buttons=0, pressed=0, shadow=0, synchronizers=1 (released), busy=0, scan_done=0, overrun=0.
REQ-029 Reset asserted mid-scan SHALL abandon the scan immediately, with no publish and no partial update.

Configuration
REQ-030 With PAD_EDGE_DETECT_EN defined, pressed SHALL behave per REQ-024; without it, pressed SHALL be tied to 0 and its previous-state register omitted.

Structure
REQ-031 Shared package pad_pkg SHALL hold the state enum, the button bit indices (UP=0..START=7) and the pin field offsets within pad_in.
REQ-032 The 2-flop synchronizer SHALL be sub-module pad_sync, parameterized by width and instanced once at 6*NUM_PADS bits.

Verification (NUM_PADS=2, SETTLE_CYCLES=4)
REQ-033 Reset, then one tick with all pins 1 -> scan_done exactly 21 cycles after the tick; buttons=16'h0000; pad_sel returns to 2'b11.
REQ-034 Pad0 pin5 low only while pad_sel[0]=1, pad1 pin8 low only while pad_sel[1]=0 -> buttons=16'h8020 (pad0 B, pad1 Start).
REQ-035 Two consecutive scans, with pad0 Up released then pressed -> second scan gives pressed[0]=1; a third scan with Up still held gives pressed[0]=0 (macro defined); pressed=0 throughout with the macro undefined.
REQ-036 Tick at cycle 5 of a scan -> overrun pulses once, scan_done still at cycle 21 of the first tick, and no second scan starts.
REQ-037 clr_n low at cycle 12 -> pad_sel=2'b11 and busy=0 asynchronously, buttons remain 0, and no scan_done occurs.
REQ-038 en=0 with a tick -> no scan; en dropped at cycle 3 of a scan -> scan completes and publishes.
